// File: rtl/spi_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : spi_arbiter
// Description : Round-robin arbiter/sequencer sharing one spi_master between
//               NREQ requesters; reports done or timeout to the frame owner.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 2048,
    parameter int IW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 m_newd,
    output logic [DW-1:0]        m_din,
    input  logic                 m_cs,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            cs_q, cs_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   din_q, din_d;
    logic            newd_q, newd_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DW-1:0]   data_arr [NREQ];
    logic            found;
    logic [IW-1:0]   win;
    logic            accept;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // Search starts at the pointer and wraps, giving the round-robin order.
    always_comb begin : p_search
        int j;
        logic [IW-1:0] idx;
        found = 1'b0;
        win   = '0;
        j     = 0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            idx = IW'(j);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign accept    = !rst && (state_q == ST_IDLE) && cs_q && found;
    assign req_ready = accept ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_d = state_q;
        cs_d    = m_cs;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        din_d   = din_q;
        newd_d  = newd_q;
        err_d   = '0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    din_d   = data_arr[win];
                    grant_d = win;
                    ptr_d   = (win == IDX_LAST) ? '0 : win + IW'(1);
                    newd_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!cs_q) begin
                    newd_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else if (cnt_q == CNT_MAX) begin
                    newd_d  = 1'b0;
                    err_d   = NREQ'(1) << grant_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_XFER: begin
                // A frame that did finish takes precedence over an expiring count.
                if (cs_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    newd_d  = 1'b0;
                    err_d   = NREQ'(1) << grant_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b1;
            ptr_q   <= '0;
            grant_q <= '0;
            din_q   <= '0;
            newd_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            din_q   <= din_d;
            newd_q  <= newd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done     = (state_q == ST_DONE) ? (NREQ'(1) << grant_q) : '0;
    assign err      = err_q;
    assign m_newd   = newd_q;
    assign m_din    = din_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule
`default_nettype wire
